// File: rtl/sub_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sub_pkg : shared FSM state type and sizing helper for the digit subtractor |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  // Digit counter width; never narrower than one bit so NDIG==1 still builds.
  function automatic int cnt_width(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sub_digit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sub_digit : combinational DIGIT-bit ripple-borrow subtractor, d = x-y-bin  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bout,
  output logic             msb_bin
);

  logic [DIGIT:0] w_brw;

  assign w_brw[0] = bin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    assign d[i]         = x[i] ^ y[i] ^ w_brw[i];
    assign w_brw[i + 1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & w_brw[i]);
  end

  assign bout    = w_brw[DIGIT];
  assign msb_bin = w_brw[DIGIT-1];

endmodule
`default_nettype wire

// File: rtl/digit_serial_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | digit_serial_subtractor : diff = a - b - bin, DIGIT bits per clock, with   |
// | valid/ready handshakes. Optional ovf port with SUB_SIGNED_OVF_EN. Rev 1.0  |
// +----------------------------------------------------------------------------+
module digit_serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy
`ifdef SUB_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CNTW = cnt_width(NDIG);
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(NDIG - 1);

  if ((WIDTH % DIGIT) != 0) begin : g_width_check
    $error("digit_serial_subtractor: WIDTH must be a multiple of DIGIT");
  end

  sub_state_t       r_state;
  sub_state_t       w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff;
  logic             r_brw;
  logic             r_bout;
  logic [CNTW-1:0]  r_cnt;

  logic             w_accept;
  logic             w_last;
  int               w_base;
  logic [DIGIT-1:0] w_d;
  logic             w_dbout;
`ifdef SUB_SIGNED_OVF_EN
  logic             w_msb_bin;
  logic             r_ovf;
`else
  logic             w_unused_msb_bin;
`endif

  assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == RUN);
  assign diff      = r_diff;
  assign bout      = r_bout;
  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_cnt == LAST_CNT);
  assign w_base    = int'(r_cnt) * DIGIT;

  sub_digit #(
    .DIGIT (DIGIT)
  ) u_digit (
    .x       (r_a[w_base +: DIGIT]),
    .y       (r_b[w_base +: DIGIT]),
    .bin     (r_brw),
    .d       (w_d),
    .bout    (w_dbout),
`ifdef SUB_SIGNED_OVF_EN
    .msb_bin (w_msb_bin)
`else
    .msb_bin (w_unused_msb_bin)
`endif
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE: begin
        // Retire and restart in one edge when a new operand set is waiting.
        if (out_ready) w_next = in_valid ? RUN : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_diff  <= '0;
      r_brw   <= 1'b0;
      r_bout  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a   <= a;
        r_b   <= b;
        r_brw <= bin;
        r_cnt <= '0;
      end else if (r_state == RUN) begin
        r_diff[w_base +: DIGIT] <= w_d;
        r_brw                   <= w_dbout;
        r_cnt                   <= r_cnt + 1'b1;
        if (w_last) r_bout <= w_dbout;
      end
    end
  end

`ifdef SUB_SIGNED_OVF_EN
  // Signed overflow: borrow into the MSB differs from borrow out of it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (!w_accept && (r_state == RUN) && w_last) begin
      r_ovf <= w_msb_bin ^ w_dbout;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_digit_serial_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_digit_serial_subtractor : directed bench, WIDTH=8 with DIGIT 4/1/2/8    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_digit_serial_subtractor;

  localparam int W  = 8;
  localparam int NS = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, in_ready, bin, out_valid, out_ready, bout, busy;
  logic [W-1:0] a, b, diff;
`ifdef SUB_SIGNED_OVF_EN
  logic         ovf;
`endif

  int errors = 0;
  int checks = 0;

  digit_serial_subtractor #(.WIDTH(W), .DIGIT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .busy(busy)
`ifdef SUB_SIGNED_OVF_EN
    , .ovf(ovf)
`endif
  );

  logic          s_valid, s_ready, s_bin;
  logic [W-1:0]  s_a, s_b;
  logic [NS-1:0] s_in_ready, s_out_valid, s_bout, s_busy;
  logic [W-1:0]  s_diff [NS];
`ifdef SUB_SIGNED_OVF_EN
  logic [NS-1:0] s_ovf;
`endif

  for (genvar k = 0; k < NS; k++) begin : g_sweep
    digit_serial_subtractor #(.WIDTH(W), .DIGIT((k == 0) ? 1 : (k == 1) ? 2 : 8)) u_dut (
      .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(s_in_ready[k]),
      .a(s_a), .b(s_b), .bin(s_bin), .out_valid(s_out_valid[k]), .out_ready(s_ready),
      .diff(s_diff[k]), .bout(s_bout[k]), .busy(s_busy[k])
`ifdef SUB_SIGNED_OVF_EN
      , .ovf(s_ovf[k])
`endif
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation from IDLE; lat counts edges from the accepting edge inclusive.
  task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic obin,
                       output logic [W-1:0] d, output logic bo, output logic ov, output int lat);
    a = oa; b = ob; bin = obin; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; a = ~oa; b = ~ob; bin = ~obin;
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    d  = diff;
    bo = bout;
`ifdef SUB_SIGNED_OVF_EN
    ov = ovf;
`else
    ov = 1'b0;
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b, required 1 0 0", in_ready, out_valid, busy);
    end
    checks++;
    if (diff !== 8'h00 || bout !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: diff=%h bout=%b, required 00 0", diff, bout);
    end
`ifdef SUB_SIGNED_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf: ovf=%b, required 0", ovf);
    end
`endif
    checks++;
    if (s_out_valid !== 3'b000 || s_in_ready !== 3'b111) begin
      errors++;
      $display("FAIL reset_sweep: out_valid=%b in_ready=%b, required 000 111", s_out_valid, s_in_ready);
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] ta [4] = '{8'h00, 8'h50, 8'hAA, 8'h00};
    logic [W-1:0] tb [4] = '{8'h01, 8'h30, 8'hAA, 8'hFF};
    logic         tc [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [W-1:0] td [4] = '{8'hFF, 8'h1F, 8'hFF, 8'h00};
    logic         te [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] d;
    logic         bo, ov;
    int           lat;
    for (int i = 0; i < 4; i++) begin
      do_op(ta[i], tb[i], tc[i], d, bo, ov, lat);
      checks++;
      if (d !== td[i] || bo !== te[i] || lat !== 3) begin
        errors++;
        $display("FAIL basic_%0d: diff=%h bout=%b lat=%0d, required %h %b 3", i, d, bo, lat, td[i], te[i]);
      end
      checks++;
      if (out_valid !== 1'b0 || diff !== td[i]) begin
        errors++;
        $display("FAIL basic_retire_%0d: out_valid=%b diff=%h, required 0 %h", i, out_valid, diff, td[i]);
      end
    end
`ifdef SUB_SIGNED_OVF_EN
    do_op(8'h80, 8'h01, 1'b0, d, bo, ov, lat);
    checks++;
    if (d !== 8'h7F || bo !== 1'b0 || ov !== 1'b1 || lat !== 3) begin
      errors++;
      $display("FAIL ovf_set: diff=%h bout=%b ovf=%b lat=%0d, required 7f 0 1 3", d, bo, ov, lat);
    end
    do_op(8'h10, 8'h01, 1'b0, d, bo, ov, lat);
    checks++;
    if (d !== 8'h0F || bo !== 1'b0 || ov !== 1'b0 || lat !== 3) begin
      errors++;
      $display("FAIL ovf_clear: diff=%h bout=%b ovf=%b lat=%0d, required 0f 0 0 3", d, bo, ov, lat);
    end
`endif
  endtask

  task automatic test_hold();
    int n;
    a = 8'h33; b = 8'h11; bin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0); a = 8'hF0 + 8'(i); b = 8'h00; bin = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_ready_%0d: in_ready=%b, required 0", i, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || diff !== 8'h22 || bout !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d: out_valid=%b diff=%h bout=%b, required 1 22 0", i, out_valid, diff, bout);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || diff !== 8'h22) begin
      errors++;
      $display("FAIL hold_release: out_valid=%b busy=%b in_ready=%b diff=%h, required 0 0 1 22",
               out_valid, busy, in_ready, diff);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] d;
    logic         bo, ov;
    int           lat;
    a = 8'h12; b = 8'h34; bin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_busy: busy=%b, required 1", busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || diff !== 8'h00 || bout !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state: busy=%b out_valid=%b in_ready=%b diff=%h bout=%b, required 0 0 1 00 0",
               busy, out_valid, in_ready, diff, bout);
    end
    do_op(8'h05, 8'h03, 1'b0, d, bo, ov, lat);
    checks++;
    if (d !== 8'h02 || bo !== 1'b0 || lat !== 3) begin
      errors++;
      $display("FAIL midrst_next: diff=%h bout=%b lat=%0d, required 02 0 3", d, bo, lat);
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 6;
    logic [W-1:0] va [N];
    logic [W-1:0] vb [N];
    logic         vc [N];
    logic [W:0]   ex;
    int           lat;
    va[0] = 8'h00; vb[0] = 8'hFF; vc[0] = 1'b1;
    va[1] = 8'hC3; vb[1] = 8'h3C; vc[1] = 1'b0;
    for (int i = 2; i < N; i++) begin
      va[i] = 8'($urandom); vb[i] = 8'($urandom); vc[i] = 1'($urandom);
    end
    out_ready = 1'b1;
    a = va[0]; b = vb[0]; bin = vc[0]; in_valid = 1'b1;
    tick();
    for (int k = 0; k < N; k++) begin
      if (k < N - 1) begin
        a = va[k+1]; b = vb[k+1]; bin = vc[k+1];
      end else begin
        in_valid = 1'b0; a = 8'hFF; b = 8'h00; bin = 1'b0;
      end
      lat = 1;
      while (!out_valid && lat < 40) begin
        tick();
        lat++;
      end
      ex = {1'b0, va[k]} - {1'b0, vb[k]} - 9'(vc[k]);
      checks++;
      if (diff !== ex[W-1:0] || bout !== ex[W] || lat !== 3) begin
        errors++;
        $display("FAIL b2b_%0d: diff=%h bout=%b lat=%0d, required %h %b 3", k, diff, bout, lat, ex[W-1:0], ex[W]);
      end
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: out_valid=%b busy=%b, required 0 0", out_valid, busy);
    end
  endtask

  task automatic test_digit_sweep();
    localparam int N = 6;
    logic [W-1:0] va [N];
    logic [W-1:0] vb [N];
    logic         vc [N];
    logic [W:0]   ex;
    int           n;
    va[0] = 8'h00; vb[0] = 8'hFF; vc[0] = 1'b1;
    va[1] = 8'h80; vb[1] = 8'h01; vc[1] = 1'b0;
    va[2] = 8'h5A; vb[2] = 8'hA5; vc[2] = 1'b0;
    for (int i = 3; i < N; i++) begin
      va[i] = 8'($urandom); vb[i] = 8'($urandom); vc[i] = 1'($urandom);
    end
    for (int v = 0; v < N; v++) begin
      s_a = va[v]; s_b = vb[v]; s_bin = vc[v]; s_valid = 1'b1;
      tick();
      s_valid = 1'b0; s_a = ~va[v]; s_b = ~vb[v];
      n = 0;
      while (!(&s_out_valid) && n < 40) begin
        tick();
        n++;
      end
      ex = {1'b0, va[v]} - {1'b0, vb[v]} - 9'(vc[v]);
      for (int k = 0; k < NS; k++) begin
        checks++;
        if (s_diff[k] !== ex[W-1:0] || s_bout[k] !== ex[W] || n >= 40) begin
          errors++;
          $display("FAIL sweep_v%0d_d%0d: diff=%h bout=%b waited=%0d, required %h %b under 40",
                   v, k, s_diff[k], s_bout[k], n, ex[W-1:0], ex[W]);
        end
`ifdef SUB_SIGNED_OVF_EN
        checks++;
        if (s_ovf[k] !== ((va[v][W-1] != vb[v][W-1]) && (ex[W-1] != va[v][W-1]))) begin
          errors++;
          $display("FAIL sweep_ovf_v%0d_d%0d: ovf=%b", v, k, s_ovf[k]);
        end
`endif
      end
      s_ready = 1'b1;
      tick();
      s_ready = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    s_valid = 1'b0; s_ready = 1'b0; s_a = '0; s_b = '0; s_bin = 1'b0;
    test_reset();
    test_basic();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    test_digit_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
